// File: rtl/uart_fifo.sv
// uart_fifo: host-side TX/RX byte FIFOs with a polling engine that moves bytes
// to and from a register-mapped UART slave.
module uart_fifo #(
   parameter int DEPTH    = 16,
   parameter int POLL_GAP = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  addr,
   input  logic [31:0] din,
   output logic [31:0] dout,
   input  logic [3:0]  lane,
   input  logic        wr,
   input  logic        valid,
   output logic [2:0]  u_addr,
   output logic [31:0] u_din,
   output logic [3:0]  u_lane,
   output logic        u_wr,
   output logic        u_valid,
   input  logic [31:0] u_dout,
   output logic        irq
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [2:0] {IDLE, STAT, STAT_WAIT, DECIDE, TX_WR, RX_ADDR, RX_CAP} state_t;
   state_t state;
   logic [3:0] gap;
   logic [7:0] tx_mem [DEPTH];
   logic [7:0] rx_mem [DEPTH];
   logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
   logic [CW-1:0] tx_cnt, rx_cnt;
   logic tx_ovf, host_data, tx_full, tx_empty, rx_full, rx_ne;
   logic tx_push, tx_pop, rx_push, rx_pop, ovf_clr, unused_bits;
   logic [31:0] status;
   assign host_data = valid && !addr[2] && lane[0];
   assign tx_full   = tx_cnt == CW'(DEPTH);
   assign tx_empty  = tx_cnt == '0;
   assign rx_full   = rx_cnt == CW'(DEPTH);
   assign rx_ne     = rx_cnt != '0;
   assign tx_push   = host_data && wr && !tx_full;
   assign tx_pop    = state == TX_WR;
   assign rx_push   = state == RX_CAP && !rx_full;
   assign rx_pop    = host_data && !wr && rx_ne;
   assign ovf_clr   = valid && wr && addr[2] && lane[0] && din[4];
   assign status    = {9'h0, 7'(rx_cnt), 1'b0, 7'(tx_cnt), 2'b0,
                       state != IDLE, tx_ovf, tx_full, tx_empty, rx_full, rx_ne};
   assign unused_bits = ^{din[31:8], u_dout[31:15], u_dout[13:9], lane[3:1], addr[1:0]};
   // Storage carries no reset; pointers and counts alone define what is valid.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp] <= din[7:0];
      if (rx_push) rx_mem[rx_wp] <= u_dout[7:0];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         rx_wp  <= '0;
         rx_rp  <= '0;
         tx_cnt <= '0;
         rx_cnt <= '0;
         tx_ovf <= 1'b0;
         irq    <= 1'b0;
         dout   <= '0;
      end else begin
         tx_wp  <= tx_wp + AW'(tx_push);
         tx_rp  <= tx_rp + AW'(tx_pop);
         rx_wp  <= rx_wp + AW'(rx_push);
         rx_rp  <= rx_rp + AW'(rx_pop);
         tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
         rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
         tx_ovf <= (tx_ovf || (host_data && wr && tx_full)) && !ovf_clr;
         irq    <= rx_ne;
         dout   <= addr[2] ? status : {24'h0, rx_mem[rx_rp]};
      end
   end
   // Bus outputs are loaded on entry to each state; u_addr holds through IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         gap     <= '0;
         u_addr  <= '0;
         u_din   <= '0;
         u_lane  <= '0;
         u_wr    <= 1'b0;
         u_valid <= 1'b0;
      end else begin
         u_valid <= 1'b0;
         u_wr    <= 1'b0;
         u_lane  <= '0;
         case (state)
            IDLE:
               if (gap == 4'(POLL_GAP)) begin
                  gap    <= '0;
                  state  <= STAT;
                  u_addr <= 3'b100;
               end else gap <= gap + 4'd1;
            STAT:      state <= STAT_WAIT;
            STAT_WAIT: state <= DECIDE;
            DECIDE:
               if (u_dout[8] && !rx_full) begin
                  state  <= RX_ADDR;
                  u_addr <= 3'b000;
               end else if (u_dout[14] && !tx_empty) begin
                  state   <= TX_WR;
                  u_addr  <= 3'b000;
                  u_valid <= 1'b1;
                  u_wr    <= 1'b1;
                  u_lane  <= 4'b0001;
                  u_din   <= {24'h0, tx_mem[tx_rp]};
               end else state <= IDLE;
            RX_ADDR: begin
               state   <= RX_CAP;
               u_valid <= 1'b1;
               u_lane  <= 4'b0001;
            end
            TX_WR, RX_CAP: begin
               state  <= STAT;
               u_addr <= 3'b100;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed bench for uart_fifo against a small UART slave model.
module tb_uart_fifo;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [2:0] addr = '0;
   logic [31:0] din = '0, dout;
   logic [3:0] lane = '0;
   logic wr = 1'b0, valid = 1'b0;
   logic [2:0] u_addr;
   logic [31:0] u_din, u_dout;
   logic [3:0] u_lane;
   logic u_wr, u_valid, irq;
   int checks = 0, errors = 0;
   int rx_offered = 0, rd_pulses = 0, wr_pulses = 0, seq = 0, last_rd = 0, last_wr = 0, bad_lane = 0;
   logic tx_idle = 1'b0;
   logic [7:0] rx_data = '0;
   logic [31:0] tx_log [64];
   logic [31:0] r;
   logic rx_rdy;
   int base, p;
   bit found;

   uart_fifo dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .din(din), .dout(dout), .lane(lane),
      .wr(wr), .valid(valid), .u_addr(u_addr), .u_din(u_din), .u_lane(u_lane),
      .u_wr(u_wr), .u_valid(u_valid), .u_dout(u_dout), .irq(irq)
   );

   always #5 clk = ~clk;
   assign rx_rdy = rx_offered > rd_pulses;

   // UART slave: status at addr[2]=1 (bit14 tx idle, bit8 rx ready), data otherwise.
   always @(posedge clk) begin
      u_dout <= u_addr[2] ? {17'h0, tx_idle, 5'h0, rx_rdy, 8'h0} : {24'h0, rx_data};
      if (u_valid) begin
         seq <= seq + 1;
         if (u_lane != 4'b0001 || u_addr != 3'b000) bad_lane <= bad_lane + 1;
         if (u_wr) begin
            tx_log[wr_pulses[5:0]] <= u_din;
            wr_pulses <= wr_pulses + 1;
            last_wr <= seq;
         end else begin
            rd_pulses <= rd_pulses + 1;
            last_rd <= seq;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic host_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      addr = a; din = d; lane = 4'b0001; wr = 1'b1; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0; wr = 1'b0;
   endtask

   task automatic host_read(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      addr = a; lane = 4'b0001; wr = 1'b0; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      d = dout;
   endtask

   task automatic status(output logic [31:0] s);
      host_read(3'b100, s);
      s = s & ~32'h20;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      idle(2);
      check("rst_bus", {29'h0, u_addr} | u_din | {28'h0, u_lane} | {30'h0, u_wr, u_valid}, 32'h0);
      check("rst_dout_irq", dout | {31'h0, irq}, 32'h0);
      rst_n = 1'b1;
      status(r);
      check("rst_status", r, 32'h4);

      tx_idle = 1'b1;
      host_write(3'b000, 32'h41);
      idle(40);
      check("tx1_pulses", wr_pulses, 1);
      check("tx1_din", tx_log[0], 32'h41);
      status(r);
      check("tx1_empty", r, 32'h4);

      tx_idle = 1'b0;
      for (int i = 0; i <= 16; i++) host_write(3'b000, i);
      idle(30);
      status(r);
      check("ovf_status", r, 32'h1018);
      check("ovf_no_tx", wr_pulses, 1);
      tx_idle = 1'b1;
      idle(250);
      check("ovf_pulses", wr_pulses, 17);
      for (int i = 1; i <= 16; i++) check("ovf_order", tx_log[i], i - 1);
      host_write(3'b100, 32'h10);
      status(r);
      check("ovf_clear", r, 32'h4);

      rx_data = 8'h5A;
      rx_offered = rd_pulses + 1;
      idle(40);
      check("rx1_pulses", rd_pulses, 1);
      status(r);
      check("rx1_status", r, 32'h10005);
      check("rx1_irq", irq, 1);
      host_read(3'b000, r);
      check("rx1_data", r, 32'h5A);
      idle(3);
      check("rx1_irq_clr", irq, 0);

      tx_idle = 1'b0;
      host_write(3'b000, 32'h77);
      idle(20);
      tx_idle = 1'b1; rx_data = 8'h33; rx_offered = rd_pulses + 1;
      idle(60);
      check("prio_rd", rd_pulses, 2);
      check("prio_wr", wr_pulses, 18);
      check("prio_order", last_rd < last_wr, 1);
      check("prio_txbyte", tx_log[17], 32'h77);
      host_read(3'b000, r);
      check("prio_rxbyte", r, 32'h33);

      base = rd_pulses;
      rx_data = 8'hC3;
      rx_offered = base + 1000;
      idle(250);
      check("full_reads", rd_pulses - base, 16);
      status(r);
      check("full_status", r, 32'h00100007);
      idle(50);
      check("full_hold", rd_pulses - base, 16);
      host_read(3'b000, r);
      check("full_pop", r, 32'hC3);
      idle(30);
      check("full_refill", rd_pulses - base, 17);
      check("lanes", bad_lane, 0);

      host_read(3'b000, r);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (u_addr == 3'b000 && !u_valid) found = 1'b1;
      end
      check("rx_addr_seen", found, 1);
      rst_n = 1'b0;
      p = rd_pulses + wr_pulses;
      #1;
      check("abort_bus", {29'h0, u_addr} | u_din | {28'h0, u_lane} | {30'h0, u_wr, u_valid}, 32'h0);
      check("abort_dout_irq", dout | {31'h0, irq}, 32'h0);
      idle(2);
      rst_n = 1'b1;
      rx_offered = rd_pulses;
      idle(30);
      check("abort_no_pulse", rd_pulses + wr_pulses, p);
      status(r);
      check("abort_counts", r, 32'h4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 SHALL expose parameter DEPTH, default 16, meaning entries per FIFO (power of two, 4..64).
REQ-002 SHALL expose parameter POLL_GAP, default 2, meaning idle cycles between status polls (0..15).
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 addr  in  3  host address, addr[2]=0 data register, addr[2]=1 status/control register.
REQ-006 din  in  32  host write data.
REQ-007 dout  out  32  host read data, registered.
REQ-008 lane  in  4  host byte enables.
REQ-009 wr  in  1  host write (1) / read (0).
REQ-010 valid  in  1  host access strobe, single cycle per access.
REQ-011 u_addr, u_din, u_lane, u_wr, u_valid  out  3/32/4/1/1  master port to the UART bus slave.
REQ-012 u_dout  in  32  UART read data, registered by the UART one cycle after u_addr.
REQ-013 irq  out  1  high while the RX FIFO is non-empty.

Function
REQ-014 SHALL hold a TX FIFO and an RX FIFO of 8-bit entries, each DEPTH deep, with wrapping pointers and a count of width log2(DEPTH)+1.
REQ-015 Host write with addr[2]=0 and lane[0] SHALL push din[7:0] into the TX FIFO; when full (pre-cycle count) the byte SHALL be dropped and sticky tx_ovf set.
REQ-016 Host read with addr[2]=0 and lane[0] SHALL pop the RX FIFO when non-empty; dout in the next cycle SHALL equal {24'h0, popped byte}; a read when empty SHALL return the head slot contents without popping.
REQ-017 Reads with addr[2]=1 SHALL return: bit0 rx_nonempty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 tx_ovf, bit5 engine busy; [14:8] tx count; [22:16] rx count; all other bits 0.
REQ-018 A host write with addr[2]=1, lane[0], din[4]=1 SHALL clear tx_ovf.
REQ-019 dout SHALL update every cycle from addr, giving one-cycle read latency.
REQ-020 A simultaneous push and pop on one FIFO SHALL leave its count unchanged; a full FIFO SHALL NOT accept a push even with a same-cycle pop.
REQ-021 The engine FSM SHALL use states IDLE, STAT, STAT_WAIT, DECIDE, TX_WR, RX_ADDR, RX_CAP.
REQ-022 IDLE SHALL wait POLL_GAP cycles, then go to STAT.
REQ-023 STAT SHALL drive u_addr=3'b100 with u_valid=0, then go to STAT_WAIT; STAT_WAIT SHALL hold u_addr for one cycle, then go to DECIDE.
REQ-024 DECIDE SHALL sample u_dout: if bit8 (RX ready) is set and the RX FIFO is not full, go to RX_ADDR; else if bit14 (TX idle) is set and the TX FIFO is not empty, go to TX_WR; else go to IDLE. RX SHALL take priority.
REQ-025 TX_WR SHALL assert u_valid=1, u_wr=1, u_addr=0, u_lane=4'b0001, u_din={24'h0, TX head} for exactly one cycle, pop the TX FIFO, then go to STAT.
REQ-026 RX_ADDR SHALL drive u_addr=0 with u_valid=0 for one cycle, then go to RX_CAP.
REQ-027 RX_CAP SHALL assert u_valid=1, u_wr=0, u_lane=4'b0001, u_addr=0 for one cycle, push u_dout[7:0] into the RX FIFO, then go to STAT.
REQ-028 Outside TX_WR and RX_CAP, u_valid and u_wr SHALL be 0.
REQ-029 The RX byte SHALL remain in the UART (not read) while the RX FIFO is full.
REQ-030 irq SHALL be registered and equal to rx_nonempty one cycle after any count change.

Reset
REQ-031 While rst_n=0: FIFO pointers and counts SHALL be 0; tx_ovf=0; FSM=IDLE with gap counter 0; dout=0; u_addr=0, u_din=0, u_lane=0, u_wr=0, u_valid=0; irq=0.
REQ-032 Reset asserted mid-transfer SHALL abort immediately with no further u_valid pulse; FIFO contents SHALL be discarded.
REQ-033 FIFO storage SHALL NOT require reset.

Verification
REQ-034 UART model idle (status bit14=1), host writes 0x41 -> exactly one u_valid&u_wr pulse with u_din=0x00000041 and u_lane=0001; then tx_empty=1.
REQ-035 UART model busy (bit14=0), host writes 17 bytes 0x00..0x10 -> tx count=16, tx_full=1, tx_ovf=1; after release, bytes 0x00..0x0F are emitted in order and 0x10 is never emitted.
REQ-036 Model raises bit8 with data 0x5A -> one read pulse (u_valid=1, u_wr=0), rx count=1, irq=1; host data read returns 0x0000005A; irq=0 afterwards.
REQ-037 Bit8 and bit14 both set, TX FIFO non-empty -> RX_CAP pulse precedes the TX_WR pulse.
REQ-038 RX FIFO filled to 16 while bit8 stays 1 -> no read pulse until the host pops; then exactly one read pulse.
REQ-039 rst_n low during RX_ADDR -> all outputs 0 next cycle, counts 0, no u_valid until polling restarts.
